serial_bit_feeder: RTL and testbench

- Upstream stage for the single-bit Mealy sequence FSM; produces the serial `x` stream that the FSM samples every clock.
- Accepts parallel words over a valid/ready handshake. Double-buffers them in a holding register plus a shift register.
- Presents one bit at a time on `x`, with a programmable hold time per bit, so the downstream FSM can be stepped at full rate or slowed for observation on board LEDs.

---
 rtl/serial_bit_feeder.sv | 128 ++++++++++++
 tb/tb_serial_bit_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Serializes handshaked parallel words onto a single registered bit stream with a
// programmable per-bit hold time; a holding register allows back-to-back words.
module serial_bit_feeder #(
  parameter int   WIDTH  = 8,
  parameter int   DIV_W  = 8,
  parameter logic IDLE_X = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] div,
  output logic             x,
  output logic             x_strobe,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0]   hold_data_q;
  logic               hold_msb_q;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               msb_q, msb_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   tick_q, tick_d;
  logic               x_q, x_d;
  logic               x_strobe_q, x_strobe_d;
  logic               word_done_q, word_done_d;

  logic accept, bit_end, word_end, load;

  assign accept   = in_valid && !hold_valid_q;
  assign bit_end  = (state_q == SHIFT) && (tick_q == div_q);
  assign word_end = bit_end && (bit_cnt_q == LAST_BIT);
  // A held word starts either from idle or seamlessly after the last bit period.
  assign load     = hold_valid_q && ((state_q == IDLE) || word_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      tick_q       <= '0;
      x_q          <= IDLE_X;
      x_strobe_q   <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      tick_q       <= tick_d;
      x_q          <= x_d;
      x_strobe_q   <= x_strobe_d;
      word_done_q  <= word_done_d;
    end
  end

  // Data registers carry no reset; they are only observed once control qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_q <= in_data;
      hold_msb_q  <= in_msb_first;
    end
    shift_q <= shift_d;
    msb_q   <= msb_d;
    div_q   <= div_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (word_end && !hold_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    msb_d        = msb_q;
    div_d        = div_q;
    bit_cnt_d    = bit_cnt_q;
    tick_d       = tick_q;
    x_d          = x_q;
    x_strobe_d   = 1'b0;
    word_done_d  = word_end;
    if (load) begin
      hold_valid_d = 1'b0;
      shift_d      = hold_data_q;
      msb_d        = hold_msb_q;
      div_d        = div;
      bit_cnt_d    = '0;
      tick_d       = '0;
      x_d          = hold_msb_q ? hold_data_q[WIDTH-1] : hold_data_q[0];
      x_strobe_d   = 1'b1;
    end else if (word_end) begin
      bit_cnt_d = '0;
      tick_d    = '0;
      x_d       = IDLE_X;
    end else if (bit_end) begin
      bit_cnt_d  = bit_cnt_q + CNT_W'(1);
      tick_d     = '0;
      shift_d    = msb_q ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
      x_d        = msb_q ? shift_q[WIDTH-2] : shift_q[1];
      x_strobe_d = 1'b1;
    end else if (state_q == SHIFT) begin
      tick_d = tick_q + DIV_W'(1);
    end
    if (accept) hold_valid_d = 1'b1;
  end

  assign in_ready  = !hold_valid_q;
  assign busy      = (state_q == SHIFT);
  assign x         = x_q;
  assign x_strobe  = x_strobe_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: directed scenarios plus random traffic, each cycle
// compared against a queue-based model of the expected bit timeline.
module tb_serial_bit_feeder;
  localparam int   W  = 8;
  localparam int   DW = 8;
  localparam logic IX = 1'b0;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_msb_first;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] div;
  logic          x, x_strobe, word_done, busy;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .DIV_W(DW), .IDLE_X(IX)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_msb_first(in_msb_first),
    .in_valid(in_valid), .in_ready(in_ready), .div(div), .x(x),
    .x_strobe(x_strobe), .word_done(word_done), .busy(busy)
  );

  typedef struct packed {logic m; logic [W-1:0] d;} word_t;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;
  bit     gap_en   = 1'b0;
  word_t  pend[$];
  logic [1:0] mq[$];
  logic   m_hv, m_pb;
  word_t  m_hold;
  logic   e_x, e_s, e_d, e_b;
  logic   acc;

  task automatic model_reset();
    mq.delete();
    m_hv = 1'b0; m_pb = 1'b0;
    e_x = IX; e_s = 1'b0; e_d = 1'b0; e_b = 1'b0;
  endtask

  // Expected outputs for the cycle following the coming edge.
  task automatic model_edge();
    logic b;
    acc = in_valid && !m_hv;
    e_d = 1'b0;
    if (mq.size() == 0) begin
      if (m_pb) e_d = 1'b1;
      if (m_hv) begin
        for (int i = 0; i < W; i++) begin
          b = m_hold.m ? m_hold.d[W-1-i] : m_hold.d[i];
          for (int j = 0; j <= int'(div); j++) mq.push_back({b, (j == 0)});
        end
        m_hv = 1'b0;
      end
    end
    if (mq.size() > 0) begin
      {e_x, e_s} = mq.pop_front();
      e_b = 1'b1;
    end else begin
      e_x = IX; e_s = 1'b0; e_b = 1'b0;
    end
    m_pb = e_b;
    if (acc) begin
      m_hv = 1'b1;
      m_hold.d = in_data;
      m_hold.m = in_msb_first;
    end
  endtask

  task automatic do_cycle();
    if (pend.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
      in_valid = 1'b1; in_data = pend[0].d; in_msb_first = pend[0].m;
    end else begin
      in_valid = 1'b0; in_data = W'($urandom); in_msb_first = 1'($urandom);
    end
    model_edge();
    @(posedge clk); #1;
    cyc++;
    if (acc) void'(pend.pop_front());
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; div = '0;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({x, x_strobe, word_done, busy, in_ready} !== {IX, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_state got=%b exp=%b", {x, x_strobe, word_done, busy, in_ready}, {IX, 4'b0001});
    else n_pass++;
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, busy} !== 2'b10) $display("FAIL reset_no_accept got=%b exp=10", {in_ready, busy});
    else n_pass++;
    in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_msb_basic();
    word_t w; logic [7:0] bits = '0; int ns = 0;
    div = 0; w.m = 1'b1; w.d = 8'b1001_0110; pend.push_back(w);
    for (int i = 0; i < 14; i++) begin
      do_cycle();
      n_checks++;
      if ({x, x_strobe, word_done, busy, in_ready} !== {e_x, e_s, e_d, e_b, ~m_hv})
        $display("FAIL msb_basic cyc=%0d got=%b exp=%b", cyc, {x, x_strobe, word_done, busy, in_ready}, {e_x, e_s, e_d, e_b, ~m_hv});
      else n_pass++;
      if (x_strobe) begin bits = {bits[6:0], x}; ns++; end
    end
    n_checks++;
    if (bits !== 8'b1001_0110 || ns != 8) $display("FAIL msb_basic_stream got=%b/%0d exp=10010110/8", bits, ns);
    else n_pass++;
  endtask

  task automatic test_lsb_div();
    word_t w; logic [7:0] bits = '0; int ns = 0, nb = 0;
    div = 2; w.m = 1'b0; w.d = 8'hA1; pend.push_back(w);
    for (int i = 0; i < 30; i++) begin
      do_cycle();
      n_checks++;
      if ({x, x_strobe, word_done, busy, in_ready} !== {e_x, e_s, e_d, e_b, ~m_hv})
        $display("FAIL lsb_div cyc=%0d got=%b exp=%b", cyc, {x, x_strobe, word_done, busy, in_ready}, {e_x, e_s, e_d, e_b, ~m_hv});
      else n_pass++;
      if (x_strobe) begin bits = {bits[6:0], x}; ns++; end
      if (busy) nb++;
    end
    n_checks++;
    if (bits !== 8'b1000_0101 || ns != 8 || nb != 24)
      $display("FAIL lsb_div_stream got=%b/%0d/%0d exp=10000101/8/24", bits, ns, nb);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    word_t w; logic [15:0] bits = '0; int ns = 0, nd = 0, d0 = 0, d1 = 0;
    div = 0;
    w.m = 1'b1; w.d = 8'hF0; pend.push_back(w);
    w.d = 8'h0F; pend.push_back(w);
    for (int i = 0; i < 22; i++) begin
      do_cycle();
      n_checks++;
      if ({x, x_strobe, word_done, busy, in_ready} !== {e_x, e_s, e_d, e_b, ~m_hv})
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, {x, x_strobe, word_done, busy, in_ready}, {e_x, e_s, e_d, e_b, ~m_hv});
      else n_pass++;
      if (x_strobe) begin bits = {bits[14:0], x}; ns++; end
      if (word_done) begin
        if (nd == 0) d0 = cyc; else d1 = cyc;
        nd++;
      end
    end
    n_checks++;
    if (bits !== 16'b1111_0000_0000_1111 || ns != 16 || nd != 2 || d1 - d0 != 8)
      $display("FAIL back_to_back_stream got=%b/%0d/%0d/%0d exp=1111000000001111/16/2/8", bits, ns, nd, d1 - d0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    word_t w; int na = 0, ns = 0;
    div = 3;
    for (int k = 0; k < 3; k++) begin
      w.m = 1'($urandom); w.d = W'($urandom); pend.push_back(w);
    end
    for (int i = 0; i < 110; i++) begin
      if (in_ready && pend.size() > 0) na++;
      do_cycle();
      n_checks++;
      if ({x, x_strobe, word_done, busy, in_ready} !== {e_x, e_s, e_d, e_b, ~m_hv})
        $display("FAIL backpressure cyc=%0d got=%b exp=%b", cyc, {x, x_strobe, word_done, busy, in_ready}, {e_x, e_s, e_d, e_b, ~m_hv});
      else n_pass++;
      if (x_strobe) ns++;
    end
    n_checks++;
    if (na != 3 || ns != 24) $display("FAIL backpressure_count got=%0d/%0d exp=3/24", na, ns);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    word_t w, w3; logic [7:0] bits = '0, expb = '0; int ns = 0;
    div = 1;
    w.m = 1'b1; w.d = 8'hC3; pend.push_back(w);
    w.m = 1'b0; w.d = 8'h3C; pend.push_back(w);
    for (int i = 0; i < 40 && ns < 5; i++) begin
      do_cycle();
      if (x_strobe) ns++;
    end
    n_checks++;
    if (ns != 5 || !m_hv) $display("FAIL reset_mid_setup got=%0d/%b exp=5/1", ns, m_hv);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({x, x_strobe, word_done, busy, in_ready} !== {IX, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_mid_async got=%b exp=%b", {x, x_strobe, word_done, busy, in_ready}, {IX, 4'b0001});
    else n_pass++;
    pend.delete(); in_valid = 1'b0; model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    w3.m = 1'($urandom); w3.d = W'($urandom);
    for (int i = 0; i < W; i++) expb = {expb[6:0], (w3.m ? w3.d[W-1-i] : w3.d[i])};
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      n_checks++;
      if ({x, x_strobe, word_done, busy, in_ready} !== {e_x, e_s, e_d, e_b, ~m_hv})
        $display("FAIL reset_mid_idle cyc=%0d got=%b exp=%b", cyc, {x, x_strobe, word_done, busy, in_ready}, {e_x, e_s, e_d, e_b, ~m_hv});
      else n_pass++;
    end
    pend.push_back(w3); ns = 0;
    for (int i = 0; i < 22; i++) begin
      do_cycle();
      n_checks++;
      if ({x, x_strobe, word_done, busy, in_ready} !== {e_x, e_s, e_d, e_b, ~m_hv})
        $display("FAIL reset_mid_restart cyc=%0d got=%b exp=%b", cyc, {x, x_strobe, word_done, busy, in_ready}, {e_x, e_s, e_d, e_b, ~m_hv});
      else n_pass++;
      if (x_strobe) begin bits = {bits[6:0], x}; ns++; end
    end
    n_checks++;
    if (bits !== expb || ns != 8) $display("FAIL reset_mid_word got=%b/%0d exp=%b/8", bits, ns, expb);
    else n_pass++;
  endtask

  task automatic test_div_change();
    word_t w; int nb = 0;
    div = 1;
    w.m = 1'b1; w.d = 8'h96; pend.push_back(w);
    w.m = 1'b0; w.d = 8'h5B; pend.push_back(w);
    for (int i = 0; i < 64; i++) begin
      if (i == 5) div = 4;
      do_cycle();
      n_checks++;
      if ({x, x_strobe, word_done, busy, in_ready} !== {e_x, e_s, e_d, e_b, ~m_hv})
        $display("FAIL div_change cyc=%0d got=%b exp=%b", cyc, {x, x_strobe, word_done, busy, in_ready}, {e_x, e_s, e_d, e_b, ~m_hv});
      else n_pass++;
      if (busy) nb++;
    end
    n_checks++;
    if (nb != 56) $display("FAIL div_change_busy got=%0d exp=56", nb);
    else n_pass++;
  endtask

  task automatic test_random();
    word_t w; int n = 0;
    gap_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      w.m = 1'($urandom); w.d = W'($urandom); pend.push_back(w);
    end
    while ((pend.size() > 0 || mq.size() > 0 || m_hv || m_pb) && n < 2000) begin
      div = DW'($urandom_range(0, 3));
      do_cycle();
      n++;
      n_checks++;
      if ({x, x_strobe, word_done, busy, in_ready} !== {e_x, e_s, e_d, e_b, ~m_hv})
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {x, x_strobe, word_done, busy, in_ready}, {e_x, e_s, e_d, e_b, ~m_hv});
      else n_pass++;
    end
    n_checks++;
    if (n >= 2000) $display("FAIL random_timeout got=%0d exp<2000", n);
    else n_pass++;
    gap_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb_basic();
    test_lsb_div();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_div_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
